// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, op classifiers.
// MADD/MSUB classification depends on the optional macro MDU_MADD_EN.
package md_pkg;

  localparam int MDUOP_W = 4;
  localparam int CNT_W   = 4;

  typedef enum logic [MDUOP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MSUB  = 4'd8
  } mduop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  function automatic logic is_mul_op(input logic [MDUOP_W-1:0] op);
    logic res;
    case (op)
      MDU_MULT, MDU_MULTU: res = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MSUB:  res = 1'b1;
`endif
      default:             res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_div_op(input logic [MDUOP_W-1:0] op);
    logic res;
    case (op)
      MDU_DIV, MDU_DIVU: res = 1'b1;
      default:           res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/md_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
interface md_if
  import md_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic               Start;
  logic [MDUOP_W-1:0] MDUOP;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               Req;
  logic               Busy;
  logic [WIDTH-1:0]   HI;
  logic [WIDTH-1:0]   LO;

  modport master (
    output Start, MDUOP, A, B, Req,
    input  Busy, HI, LO
  );

  modport slave (
    input  Start, MDUOP, A, B, Req,
    output Busy, HI, LO
  );

endinterface

// File: rtl/md_datapath.sv
// Combinational product/quotient/remainder from the latched operands.
// With MDU_MADD_EN defined, also produces the MADD/MSUB accumulate results.
module md_datapath
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [MDUOP_W-1:0] op,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   hi_res,
  output logic [WIDTH-1:0]   lo_res,
  output logic               res_valid
);

  logic [2*WIDTH-1:0] a_sx, b_sx, prod_s, prod_u;
  logic [WIDTH-1:0]   a_mag, b_mag, b_mag_safe, b_safe;
  logic [WIDTH-1:0]   sq_mag, sr_mag, sq, sr, uq, ur;
  logic               a_neg, b_neg, div_zero;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc;
`endif

  // Arithmetic kernels; signed divide works on magnitudes so MIN / -1 wraps to MIN with no overflow trap.
  always_comb begin
    a_sx       = {{WIDTH{a[WIDTH-1]}}, a};
    b_sx       = {{WIDTH{b[WIDTH-1]}}, b};
    prod_s     = a_sx * b_sx;
    prod_u     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    div_zero   = (b == {WIDTH{1'b0}});
    a_neg      = a[WIDTH-1];
    b_neg      = b[WIDTH-1];
    a_mag      = a_neg ? (-a) : a;
    b_mag      = b_neg ? (-b) : b;
    b_mag_safe = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    b_safe     = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    sq_mag     = a_mag / b_mag_safe;
    sr_mag     = a_mag % b_mag_safe;
    sq         = (a_neg ^ b_neg) ? (-sq_mag) : sq_mag;
    sr         = a_neg ? (-sr_mag) : sr_mag;
    uq         = a / b_safe;
    ur         = a % b_safe;
  end

  // Result selection by op; divide-by-zero and non-arithmetic ops leave HI/LO alone.
  always_comb begin
    hi_res    = hi;
    lo_res    = lo;
    res_valid = 1'b0;
`ifdef MDU_MADD_EN
    acc       = {hi, lo};
`endif
    case (op)
      MDU_MULT: begin
        {hi_res, lo_res} = prod_s;
        res_valid        = 1'b1;
      end
      MDU_MULTU: begin
        {hi_res, lo_res} = prod_u;
        res_valid        = 1'b1;
      end
      MDU_DIV: begin
        if (!div_zero) begin
          hi_res    = sr;
          lo_res    = sq;
          res_valid = 1'b1;
        end else begin
          res_valid = 1'b0;
        end
      end
      MDU_DIVU: begin
        if (!div_zero) begin
          hi_res    = ur;
          lo_res    = uq;
          res_valid = 1'b1;
        end else begin
          res_valid = 1'b0;
        end
      end
`ifdef MDU_MADD_EN
      MDU_MADD: begin
        acc              = {hi, lo} + prod_s;
        {hi_res, lo_res} = acc;
        res_valid        = 1'b1;
      end
      MDU_MSUB: begin
        acc              = {hi, lo} - prod_s;
        {hi_res, lo_res} = acc;
        res_valid        = 1'b1;
      end
`endif
      default: begin
        res_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle HI/LO multiply/divide unit: IDLE/MUL/DIV control with a down-counter and registered outputs.
// Optional MADD/MSUB support is enabled by defining MDU_MADD_EN.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [MDUOP_W-1:0] op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   hi_res, lo_res;
  logic               res_valid;
  logic               issue_ok;

  md_datapath #(.WIDTH(WIDTH)) u_datapath (
    .a         (a_q),
    .b         (b_q),
    .op        (op_q),
    .hi        (hi_q),
    .lo        (lo_q),
    .hi_res    (hi_res),
    .lo_res    (lo_res),
    .res_valid (res_valid)
  );

  // Next-state, counter and HI/LO write control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    issue_ok = bus.Start && !bus.Req;
    case (state_q)
      ST_IDLE: begin
        if (issue_ok && is_mul_op(bus.MDUOP)) begin
          state_d = ST_MUL;
          cnt_d   = MUL_CNT;
          a_d     = bus.A;
          b_d     = bus.B;
          op_d    = bus.MDUOP;
        end else if (issue_ok && is_div_op(bus.MDUOP)) begin
          state_d = ST_DIV;
          cnt_d   = DIV_CNT;
          a_d     = bus.A;
          b_d     = bus.B;
          op_d    = bus.MDUOP;
        end else if (issue_ok && (bus.MDUOP == MDU_MTHI)) begin
          hi_d = bus.A;
        end else if (issue_ok && (bus.MDUOP == MDU_MTLO)) begin
          lo_d = bus.A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        // The final busy edge commits the result, so HI/LO change together with Busy falling.
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          if (res_valid) begin
            hi_d = hi_res;
            lo_d = lo_res;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      op_q    <= MDU_NONE;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
